stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core_pkg.sv | 24 ++
 rtl/stopwatch_core_if.sv | 23 ++
 rtl/stopwatch_core_bcd_digit.sv | 38 +++
 rtl/stopwatch_core.sv | 122 ++++++++++++
 tb/tb_stopwatch_core.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_core_pkg.sv
// Shared constants for the stopwatch slice: clock dividers, digit format,
// FSM encodings and anode decoding.
package stopwatch_core_pkg;

    localparam int unsigned SYS_CLK_HZ    = 50_000_000;
    localparam int unsigned TICK_HZ       = 100;
    localparam int unsigned TICK_DIV      = SYS_CLK_HZ / (2 * TICK_HZ);
    localparam int unsigned SCAN_DIV      = SYS_CLK_HZ / 4000;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned SEC_LIMIT_DEF = 59;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LAP   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    function automatic logic [3:0] an_decode(input logic [1:0] sel, input logic active_low);
        logic [3:0] oh;
        oh = 4'b0001 << sel;
        return active_low ? ~oh : oh;
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/display bundle between the clock generator/buttons (master)
// and the stopwatch core (slave).
interface stopwatch_core_if;
    logic        tick_100;
    logic [1:0]  clk_ctl;
    logic        start_stop;
    logic        lap_reset;
    logic [15:0] disp_bcd;
    logic [3:0]  scan_bcd;
    logic [3:0]  scan_an;
    logic [1:0]  state;
    logic        wrap;

    modport master (
        output tick_100, clk_ctl, start_stop, lap_reset,
        input  disp_bcd, scan_bcd, scan_an, state, wrap
    );

    modport slave (
        input  tick_100, clk_ctl, start_stop, lap_reset,
        output disp_bcd, scan_bcd, scan_an, state, wrap
    );
endinterface

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD counter digit that wraps to 0 after reaching limit; carry flags
// the increment that wraps it.
module bcd_digit
    import stopwatch_core_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [DIGIT_W-1:0] limit,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q == limit) ? '0 : q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == limit);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: SS.cc BCD counter with run/lap/pause control and a
// combinational digit scan for a multiplexed 4-digit display.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int unsigned SEC_LIMIT     = SEC_LIMIT_DEF,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_core_if.slave sw
);

    localparam logic [DIGIT_W-1:0] SEC_T_LIM = DIGIT_W'(SEC_LIMIT / 10);
    localparam logic [DIGIT_W-1:0] SEC_O_LIM = DIGIT_W'(SEC_LIMIT % 10);

    logic               tick_q;
    logic [1:0]         state_q, state_d;
    logic [15:0]        lap_q, lap_d;
    logic               wrap_q;

    logic               cnt_en;
    logic               cnt_inc;
    logic               clr;
    logic               ss, lr;
    logic [DIGIT_W-1:0] cs_o, cs_t, s_o, s_t;
    logic               c0, c1, c2, c3;
    logic [DIGIT_W-1:0] s_o_lim;
    logic [15:0]        count;

    assign cnt_en  = sw.tick_100 & ~tick_q;
    assign cnt_inc = cnt_en & ((state_q == ST_RUN) || (state_q == ST_LAP));
    assign ss      = sw.start_stop;
    assign lr      = sw.lap_reset & ~sw.start_stop;
    assign count   = {s_t, s_o, cs_t, cs_o};

    // Seconds-ones only wraps early on the last tens value of the range.
    assign s_o_lim = (s_t == SEC_T_LIM) ? SEC_O_LIM : DIGIT_W'(9);

    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr = 1'b1;
                if (ss) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ss) begin
                    state_d = ST_PAUSE;
                end else if (lr) begin
                    state_d = ST_LAP;
                    lap_d   = count;
                end
            end
            ST_LAP: begin
                if (ss)      state_d = ST_PAUSE;
                else if (lr) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (ss) begin
                    state_d = ST_RUN;
                end else if (lr) begin
                    state_d = ST_IDLE;
                    lap_d   = '0;
                    clr     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q  <= 1'b0;
            state_q <= ST_IDLE;
            lap_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q  <= sw.tick_100;
            state_q <= state_d;
            lap_q   <= lap_d;
            wrap_q  <= c3;
        end
    end

    bcd_digit u_cs_ones (
        .clk(clk), .rst(rst), .clr(clr), .inc(cnt_inc),
        .limit(DIGIT_W'(9)), .q(cs_o), .carry(c0)
    );

    bcd_digit u_cs_tens (
        .clk(clk), .rst(rst), .clr(clr), .inc(c0),
        .limit(DIGIT_W'(9)), .q(cs_t), .carry(c1)
    );

    bcd_digit u_sec_ones (
        .clk(clk), .rst(rst), .clr(clr), .inc(c1),
        .limit(s_o_lim), .q(s_o), .carry(c2)
    );

    bcd_digit u_sec_tens (
        .clk(clk), .rst(rst), .clr(clr), .inc(c2),
        .limit(SEC_T_LIM), .q(s_t), .carry(c3)
    );

    assign sw.disp_bcd = (state_q == ST_LAP) ? lap_q : count;
    assign sw.state    = state_q;
    assign sw.wrap     = wrap_q;
    assign sw.scan_an  = an_decode(sw.clk_ctl, AN_ACTIVE_LOW);

    always_comb begin
        case (sw.clk_ctl)
            2'd0:    sw.scan_bcd = sw.disp_bcd[3:0];
            2'd1:    sw.scan_bcd = sw.disp_bcd[7:4];
            2'd2:    sw.scan_bcd = sw.disp_bcd[11:8];
            default: sw.scan_bcd = sw.disp_bcd[15:12];
        endcase
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: reset, counting, lap, pause,
// wrap, button priority and digit scan.
module tb_stopwatch_core;

    logic clk;
    logic rst;
    int unsigned n_chk;
    int unsigned n_bad;

    stopwatch_core_if sw_if ();

    stopwatch_core #(
        .SEC_LIMIT(59),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            sw_if.tick_100 = 1'b1;
            step();
            sw_if.tick_100 = 1'b0;
            step();
        end
    endtask

    task automatic press(input logic ss, input logic lr);
        sw_if.start_stop = ss;
        sw_if.lap_reset  = lr;
        step();
        sw_if.start_stop = 1'b0;
        sw_if.lap_reset  = 1'b0;
    endtask

    logic [3:0] exp_an [4];
    logic [3:0] exp_dg [4];

    initial begin
        n_chk = 0;
        n_bad = 0;
        exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_dg = '{4'h4, 4'h3, 4'h2, 4'h1};

        rst = 1'b1;
        sw_if.tick_100   = 1'b0;
        sw_if.clk_ctl    = 2'd2;
        sw_if.start_stop = 1'b0;
        sw_if.lap_reset  = 1'b0;
        step();
        sw_if.tick_100 = 1'b1;
        step();
        step();
        chk("rst_state", 16'(sw_if.state), 16'd0);
        chk("rst_disp", sw_if.disp_bcd, 16'h0000);
        chk("rst_wrap", 16'(sw_if.wrap), 16'd0);
        chk("rst_scan_an", 16'(sw_if.scan_an), 16'b1011);
        chk("rst_scan_bcd", 16'(sw_if.scan_bcd), 16'd0);
        sw_if.tick_100 = 1'b0;
        rst = 1'b0;
        step();

        // IDLE ignores lap_reset and ticks
        press(1'b0, 1'b1);
        ticks(3);
        chk("idle_state", 16'(sw_if.state), 16'd0);
        chk("idle_disp", sw_if.disp_bcd, 16'h0000);

        press(1'b1, 1'b0);
        chk("run_state", 16'(sw_if.state), 16'd1);
        ticks(150);
        chk("run150_disp", sw_if.disp_bcd, 16'h0150);
        chk("run150_state", 16'(sw_if.state), 16'd1);

        ticks(170);
        chk("run320_disp", sw_if.disp_bcd, 16'h0320);
        press(1'b0, 1'b1);
        chk("lap_state", 16'(sw_if.state), 16'd2);
        ticks(50);
        chk("lap_hold_disp", sw_if.disp_bcd, 16'h0320);
        chk("lap_hold_state", 16'(sw_if.state), 16'd2);
        press(1'b0, 1'b1);
        chk("lap_exit_state", 16'(sw_if.state), 16'd1);
        chk("lap_exit_disp", sw_if.disp_bcd, 16'h0370);

        // start_stop coincident with cnt_en: the increment still lands
        sw_if.tick_100   = 1'b1;
        sw_if.start_stop = 1'b1;
        step();
        sw_if.tick_100   = 1'b0;
        sw_if.start_stop = 1'b0;
        chk("pause_state", 16'(sw_if.state), 16'd3);
        chk("pause_inc_disp", sw_if.disp_bcd, 16'h0371);
        step();
        ticks(10);
        chk("pause_frozen", sw_if.disp_bcd, 16'h0371);
        press(1'b0, 1'b1);
        chk("clear_state", 16'(sw_if.state), 16'd0);
        chk("clear_disp", sw_if.disp_bcd, 16'h0000);

        press(1'b1, 1'b0);
        ticks(5);
        press(1'b1, 1'b0);
        chk("pause2_state", 16'(sw_if.state), 16'd3);
        chk("pause2_disp", sw_if.disp_bcd, 16'h0005);
        // both buttons plus cnt_en while paused: resume, no clear, no increment
        sw_if.tick_100   = 1'b1;
        sw_if.start_stop = 1'b1;
        sw_if.lap_reset  = 1'b1;
        step();
        sw_if.tick_100   = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.lap_reset  = 1'b0;
        chk("both_state", 16'(sw_if.state), 16'd1);
        chk("both_disp", sw_if.disp_bcd, 16'h0005);
        step();

        ticks(1229);
        press(1'b1, 1'b0);
        chk("scan_pre_disp", sw_if.disp_bcd, 16'h1234);
        for (int unsigned k = 0; k < 4; k++) begin
            sw_if.clk_ctl = 2'(k);
            #1;
            chk("scan_bcd", 16'(sw_if.scan_bcd), 16'(exp_dg[k]));
            chk("scan_an", 16'(sw_if.scan_an), 16'(exp_an[k]));
        end

        press(1'b1, 1'b0);
        ticks(4764);
        chk("pre_wrap_disp", sw_if.disp_bcd, 16'h5998);
        sw_if.tick_100 = 1'b1;
        step();
        chk("5999_disp", sw_if.disp_bcd, 16'h5999);
        chk("5999_wrap", 16'(sw_if.wrap), 16'd0);
        sw_if.tick_100 = 1'b0;
        step();
        chk("5999_wrap_lo", 16'(sw_if.wrap), 16'd0);
        sw_if.tick_100 = 1'b1;
        step();
        chk("wrap_disp", sw_if.disp_bcd, 16'h0000);
        chk("wrap_pulse", 16'(sw_if.wrap), 16'd1);
        sw_if.tick_100 = 1'b0;
        step();
        chk("wrap_end", 16'(sw_if.wrap), 16'd0);
        chk("wrap_after_disp", sw_if.disp_bcd, 16'h0000);

        // asynchronous reset in the middle of a clock period
        ticks(3);
        chk("pre_arst_disp", sw_if.disp_bcd, 16'h0003);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_disp", sw_if.disp_bcd, 16'h0000);
        chk("arst_state", 16'(sw_if.state), 16'd0);
        step();
        rst = 1'b0;
        step();
        ticks(3);
        chk("post_arst_state", 16'(sw_if.state), 16'd0);
        chk("post_arst_disp", sw_if.disp_bcd, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
